// File: rtl/add_arbiter.sv
// Shared 32-bit adder behind a round-robin arbiter, with a single-entry tagged response buffer.
// Define CALC_ARB_FIXED_PRIO_EN to switch the arbiter to fixed priority (lowest index wins).
package calculator_pkg;
  localparam int DATA_W = 32;
endpackage

module adder32
  import calculator_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);
  // Carry-out is intentionally dropped: results are modulo 2^32.
  assign sum_o = a_i + b_i;
endmodule

module add_arbiter
  import calculator_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [DATA_W-1:0]               rsp_sum_o,
  output logic [ID_W-1:0]                 rsp_id_o,
  output logic [15:0]                     ops_cnt_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                can_issue, rsp_fire, gnt_any, gnt_fire;
  logic [ID_W-1:0]     gnt_idx;
  logic [DATA_W-1:0]   add_sum;

`ifndef CALC_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  int                  idx;
`endif

  // Grant selection; the descending loop lets the closest candidate win last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
`ifdef CALC_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        gnt_idx = ID_W'(i);
        gnt_any = 1'b1;
      end
    end
`else
    idx = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid_i[idx]) begin
        gnt_idx = ID_W'(idx);
        gnt_any = 1'b1;
      end
    end
`endif
  end

  // Reset gates issue so no grant is shown while rst_ni is held low.
  assign rsp_fire  = (state_q == FULL) && rsp_ready_i;
  assign can_issue = rst_ni && ((state_q == EMPTY) || rsp_ready_i);
  assign gnt_fire  = can_issue && gnt_any;

  assign req_ready_o = gnt_fire ? (NUM_REQ'(1) << gnt_idx) : '0;

  adder32 u_adder (
    .a_i   (req_a_i[gnt_idx]),
    .b_i   (req_b_i[gnt_idx]),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
`ifndef CALC_ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    if (rsp_fire) begin
      state_d = EMPTY;
      cnt_d   = cnt_q + 16'd1;
    end
    if (gnt_fire) begin
      state_d = FULL;
      sum_d   = add_sum;
      id_d    = gnt_idx;
`ifndef CALC_ARB_FIXED_PRIO_EN
      rr_ptr_d = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + ID_W'(1);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      sum_q    <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
`ifndef CALC_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
`ifndef CALC_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_sum_o   = sum_q;
  assign rsp_id_o    = id_q;
  assign ops_cnt_o   = cnt_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter (NUM_REQ=2); honours CALC_ARB_FIXED_PRIO_EN for the fairness expectation.
module tb_add_arbiter;
  localparam int NUM_REQ = 2;

  logic                  clk, rst_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [NUM_REQ-1:0][31:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [31:0]           rsp_sum;
  logic [0:0]            rsp_id;
  logic [15:0]           ops_cnt;
  int                    nchk, nerr;

  add_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_sum_o(rsp_sum), .rsp_id_o(rsp_id), .ops_cnt_o(ops_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    #1;
    nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL reset_ready: got %b exp 00", req_ready); end
    nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b exp 0", rsp_valid); end
    nchk++; if (ops_cnt !== 16'h0) begin nerr++; $display("FAIL reset_cnt: got %h exp 0000", ops_cnt); end
    nchk++; if (rsp_sum !== 32'h0 || rsp_id !== 1'b0) begin nerr++; $display("FAIL reset_data: got %h/%0d exp 0/0", rsp_sum, rsp_id); end
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_a[0] = 32'h5; req_b[0] = 32'h7; req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL single_ready: got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    nchk++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL single_valid: got %b exp 1", rsp_valid); end
    nchk++; if (rsp_sum !== 32'hC || rsp_id !== 1'b0) begin nerr++; $display("FAIL single_data: got %h/%0d exp 0000000c/0", rsp_sum, rsp_id); end
    @(negedge clk);
    nchk++; if (ops_cnt !== 16'd1 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL single_cnt: got %0d/%b exp 1/0", ops_cnt, rsp_valid); end
  endtask

  task automatic test_wrap();
    req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'h1; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    nchk++; if (rsp_sum !== 32'h0 || rsp_id !== 1'b0) begin nerr++; $display("FAIL wrap_ff: got %h/%0d exp 0/0", rsp_sum, rsp_id); end
    req_a[1] = 32'h8000_0000; req_b[1] = 32'h8000_0000; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    nchk++; if (rsp_sum !== 32'h0 || rsp_id !== 1'b1) begin nerr++; $display("FAIL wrap_80: got %h/%0d exp 0/1", rsp_sum, rsp_id); end
    @(negedge clk);
    nchk++; if (ops_cnt !== 16'd3 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL wrap_cnt: got %0d/%b exp 3/0", ops_cnt, rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [0:0]  exp_id;
    logic [31:0] exp_sum;
    int          bad;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a[0] = 32'd10; req_b[0] = 32'd0; req_a[1] = 32'd20; req_b[1] = 32'd0;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef CALC_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = 1'(i % 2);
`endif
      exp_sum = (exp_id == 1'b0) ? 32'd10 : 32'd20;
      bad = (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== exp_sum) ? 1 : 0;
      nchk++; if (bad != 0) begin nerr++; $display("FAIL fair_%0d: got v=%b id=%0d sum=%0d exp v=1 id=%0d sum=%0d", i, rsp_valid, rsp_id, rsp_sum, exp_id, exp_sum); end
    end
    req_valid = 2'b00;
    @(negedge clk);
    nchk++; if (ops_cnt !== 16'd8 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL fair_cnt: got %0d/%b exp 8/0", ops_cnt, rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_a[0] = 32'h1234_0000; req_b[0] = 32'h0000_5678; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10; req_a[1] = 32'd1; req_b[1] = 32'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL bp_ready_%0d: got %b exp 00", i, req_ready); end
      nchk++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'h1234_5678 || rsp_id !== 1'b0 || ops_cnt !== 16'd8) begin
        nerr++; $display("FAIL bp_hold_%0d: got v=%b sum=%h id=%0d cnt=%0d exp 1/12345678/0/8", i, rsp_valid, rsp_sum, rsp_id, ops_cnt);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    nchk++; if (req_ready !== 2'b10) begin nerr++; $display("FAIL bp_release_ready: got %b exp 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    nchk++; if (rsp_sum !== 32'd3 || rsp_id !== 1'b1 || ops_cnt !== 16'd9) begin nerr++; $display("FAIL bp_release: got %h/%0d/%0d exp 3/1/9", rsp_sum, rsp_id, ops_cnt); end
    @(negedge clk);
    nchk++; if (ops_cnt !== 16'd10 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain: got %0d/%b exp 10/0", ops_cnt, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_a[0] = 32'd3; req_b[0] = 32'd4; req_valid = 2'b01;
    @(negedge clk);
    req_a[1] = 32'd9; req_b[1] = 32'd9; req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    nchk++; if (rsp_valid !== 1'b0 || ops_cnt !== 16'd0) begin nerr++; $display("FAIL rmid_state: got %b/%0d exp 0/0", rsp_valid, ops_cnt); end
    nchk++; if (req_ready !== 2'b00 || rsp_sum !== 32'h0) begin nerr++; $display("FAIL rmid_outs: got %b/%h exp 00/0", req_ready, rsp_sum); end
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL rmid_first_gnt: got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    nchk++; if (rsp_sum !== 32'd7 || rsp_id !== 1'b0) begin nerr++; $display("FAIL rmid_rsp: got %h/%0d exp 7/0", rsp_sum, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_valid = 2'b01; rsp_ready = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00; rsp_ready = 1'b0;
    nchk++; if (ops_cnt !== 16'hFFFF || rsp_valid !== 1'b1) begin nerr++; $display("FAIL cnt_preload: got %h/%b exp ffff/1", ops_cnt, rsp_valid); end
    @(negedge clk);
    nchk++; if (ops_cnt !== 16'hFFFF) begin nerr++; $display("FAIL cnt_stall: got %h exp ffff", ops_cnt); end
    rsp_ready = 1'b1;
    @(negedge clk);
    nchk++; if (ops_cnt !== 16'h0000 || rsp_valid !== 1'b0) begin nerr++; $display("FAIL cnt_wrap: got %h/%b exp 0000/0", ops_cnt, rsp_valid); end
  endtask

  initial begin
    nchk = 0; nerr = 0;
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
